salsa_stream: RTL
=================

Name: salsa_stream

Overview:
- Parametrised Salsa20-family keystream generator; successor to the fixed 20-round, 128-bit-output Salsa core.
- Adds:
  - selectable round count and output width
  - 128- and 256-bit key modes
  - valid/ready keystream streaming
  - multi-block bursts with automatic counter increment
  - counter wrap flag and abort
- Sits between the key/nonce register interface and the XOR datapath of the stream-cipher wrapper.

Parameters:
- ROUNDS, 20, number of single rounds per block; even, 8..20 (Salsa20/8, /12, /20).
- OUT_W, 128, keystream beat width; one of 32, 64, 128, 256, 512.
- BLK_W, 16, width of the burst block-count input.

Ports:
- CLK  in  1  clock
- RST_N  in  1  reset, asynchronous, active-low
- KEY_LOAD  in  1  capture KEY_IN and KEY_MODE (IDLE only)
- KEY_MODE  in  1  0 = 128-bit key (tau constants), 1 = 256-bit key (sigma constants)
- KEY_IN  in  256  key; word k = KEY_IN[32k+31:32k]
- NONCE_LOAD  in  1  capture NONCE_IN and CTR_IN (IDLE only)
- NONCE_IN  in  64  nonce
- CTR_IN  in  64  initial block counter
- START  in  1  begin burst of BLOCKS blocks (IDLE only)
- BLOCKS  in  BLK_W  blocks in burst; 0 = no-op
- ABORT  in  1  cancel burst
- KS_READY  in  1  downstream ready
- KS_VALID  out  1  keystream beat valid
- KS_DATA  out  OUT_W  keystream beat, low words first
- KS_LAST  out  1  final beat of current block
- BUSY  out  1  state != IDLE
- CTR_OUT  out  64  current block counter
- CTR_WRAP  out  1  one-cycle pulse when counter wraps 2^64-1 -> 0

Behaviour:
- Reset values: all outputs 0, state IDLE; key, nonce, counter and matrix registers all 0.
- Matrix word i = data[32i+31:32i].
  - Constants:
    - Mode 1 (sigma): w0=61707865, w5=3320646e, w10=79622d32, w15=6b206574.
    - Mode 0 (tau): w0=61707865, w5=3120646e, w10=79622d36, w15=6b206574.
  - w1..w4 = key words 0..3.
  - w11..w14 = key words 4..7 (mode 1) or key words 0..3 again (mode 0).
  - w6,w7 = nonce low/high; w8,w9 = counter low/high.
- States: IDLE, INIT, ROUND, FINAL, OUT.
- IDLE:
  - KEY_LOAD and NONCE_LOAD are captured; both may occur in the same cycle.
  - START with BLOCKS != 0: remaining <= BLOCKS, go to INIT.
  - A load and START in the same cycle: the burst uses the newly loaded values.
  - Loads outside IDLE are ignored.
- INIT: load matrix and copy; rc <= 0; go to ROUND.
- ROUND:
  - One round per cycle; even rc = column round, odd rc = row round.
  - Adds are mod 2^32; rotate amounts 7, 9, 13, 18.
  - After ROUNDS cycles, go to FINAL.
- FINAL: word-wise add matrix + copy (mod 2^32); KS_VALID <= 1; go to OUT.
- OUT:
  - KS_DATA = data[OUT_W-1:0].
  - On KS_VALID & KS_READY: shift data right by OUT_W and advance the beat counter.
  - KS_DATA/KS_VALID are held stable while KS_READY is low.
  - 512/OUT_W beats per block; KS_LAST is high on the last beat.
  - After the last handshake: counter += 1 (64-bit wrap, CTR_WRAP pulses on wrap) and remaining -= 1.
  - Then go to INIT if remaining != 0, else IDLE. KS_VALID drops unless the next beat is present.
- Latency: first KS_VALID is registered ROUNDS+2 edges after the edge sampling START (22 for ROUNDS=20). Per-block throughput is ROUNDS+2+512/OUT_W cycles with KS_READY held high.
- ABORT (any non-IDLE state):
  - Next edge: IDLE, KS_VALID=0, matrix cleared.
  - Counter is not incremented for the unfinished block.
  - ABORT has priority over a simultaneous handshake.
  - ABORT in IDLE is ignored.
- START while BUSY is ignored.
- Async reset mid-burst returns everything to reset values immediately.

Decomposition:
- Package salsa_pkg: state enum, sigma/tau constant words, rotate amounts, function word(matrix, i).
- Sub-module salsa_round (combinational): inputs 512-bit matrix and row/column select; output 512-bit matrix. Built from four quarter-rounds with index tables selected by mode.

Test Plan:
- Zero key, zero nonce, counter 0, mode 1, ROUNDS=20, OUT_W=128, BLOCKS=1, KS_READY=1 -> KS_VALID at edge 22; 4 beats bit-exact with the salsa_pkg software model; KS_LAST on beat 4; CTR_OUT=1.
- Same stimulus with mode 0 and key words 0..3 = 03020100, 07060504, 0b0a0908, 0f0e0d0c -> output matches the model with tau constants; distinct from mode 1.
- BLOCKS=3, KS_READY toggled 1/0 every cycle -> 12 beats; data held stable while stalled; blocks 1..3 use counters 0, 1, 2; CTR_OUT=3; BUSY falls after the last beat.
- CTR_IN=ffffffff_ffffffff, BLOCKS=2 -> second block uses counter 0; CTR_WRAP pulses exactly one cycle; CTR_OUT=1.
- ABORT asserted on round 5 of block 2 of 4 -> IDLE next edge; KS_VALID=0; CTR_OUT = start+1; a new START produces correct output from that counter.
- KEY_LOAD and START in the same cycle; then KEY_LOAD and NONCE_LOAD during a burst -> first burst uses the new key; loads during the burst are ignored; RST_N low mid-OUT zeroes all outputs asynchronously.

Source files
------------

// File: rtl/salsa_pkg.sv
// Shared types, constants and helpers for the Salsa20-family keystream generator.
// Matrix word i occupies bits [32i+31:32i] of a 512-bit vector.
package salsa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_OUT   = 3'd4
  } state_e;

  localparam logic [31:0] CONST_W0  = 32'h61707865;
  localparam logic [31:0] CONST_W15 = 32'h6b206574;
  localparam logic [31:0] SIGMA_W5  = 32'h3320646e;
  localparam logic [31:0] SIGMA_W10 = 32'h79622d32;
  localparam logic [31:0] TAU_W5    = 32'h3120646e;
  localparam logic [31:0] TAU_W10   = 32'h79622d36;

  localparam int unsigned ROT_A = 7;
  localparam int unsigned ROT_B = 9;
  localparam int unsigned ROT_C = 13;
  localparam int unsigned ROT_D = 18;

  function automatic logic [31:0] word(input logic [511:0] m, input int i);
    return m[32*i +: 32];
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [511:0] init_matrix(input logic [255:0] key, input logic mode,
                                               input logic [63:0] nonce, input logic [63:0] ctr);
    logic [511:0] m;
    m = '0;
    m[31:0]         = CONST_W0;
    m[32*5 +: 32]   = mode ? SIGMA_W5 : TAU_W5;
    m[32*10 +: 32]  = mode ? SIGMA_W10 : TAU_W10;
    m[32*15 +: 32]  = CONST_W15;
    for (int k = 0; k < 4; k++) begin
      m[32*(1+k) +: 32]  = key[32*k +: 32];
      // 128-bit keys repeat the same four words in the upper key slots
      m[32*(11+k) +: 32] = mode ? key[32*(k+4) +: 32] : key[32*k +: 32];
    end
    m[32*6 +: 32] = nonce[31:0];
    m[32*7 +: 32] = nonce[63:32];
    m[32*8 +: 32] = ctr[31:0];
    m[32*9 +: 32] = ctr[63:32];
    return m;
  endfunction

endpackage

// File: rtl/salsa_round.sv
// One Salsa single round: four independent quarter-rounds over either the
// column sets (row_sel = 0) or the row sets (row_sel = 1).
module salsa_round
  import salsa_pkg::*;
(
  input  logic [511:0] matrix_i,
  input  logic         row_sel,
  output logic [511:0] matrix_o
);

  // Each entry lists the {a, b, c, d} word indices of one quarter-round
  localparam logic [3:0] COL_IDX [4][4] = '{
    '{4'd0,  4'd4,  4'd8,  4'd12},
    '{4'd5,  4'd9,  4'd13, 4'd1},
    '{4'd10, 4'd14, 4'd2,  4'd6},
    '{4'd15, 4'd3,  4'd7,  4'd11}
  };
  localparam logic [3:0] ROW_IDX [4][4] = '{
    '{4'd0,  4'd1,  4'd2,  4'd3},
    '{4'd5,  4'd6,  4'd7,  4'd4},
    '{4'd10, 4'd11, 4'd8,  4'd9},
    '{4'd15, 4'd12, 4'd13, 4'd14}
  };

  function automatic logic [511:0] do_round(input logic [511:0] m, input logic row);
    logic [31:0]  w [16];
    logic [3:0]   a, b, c, d;
    logic [511:0] r;
    for (int i = 0; i < 16; i++) w[i] = word(m, i);
    for (int q = 0; q < 4; q++) begin
      a = row ? ROW_IDX[q][0] : COL_IDX[q][0];
      b = row ? ROW_IDX[q][1] : COL_IDX[q][1];
      c = row ? ROW_IDX[q][2] : COL_IDX[q][2];
      d = row ? ROW_IDX[q][3] : COL_IDX[q][3];
      w[b] = w[b] ^ rotl(w[a] + w[d], ROT_A);
      w[c] = w[c] ^ rotl(w[b] + w[a], ROT_B);
      w[d] = w[d] ^ rotl(w[c] + w[b], ROT_C);
      w[a] = w[a] ^ rotl(w[d] + w[c], ROT_D);
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = w[i];
    return r;
  endfunction

  assign matrix_o = do_round(matrix_i, row_sel);

endmodule

// File: rtl/salsa_stream.sv
// Salsa20-family keystream generator: key/nonce capture, iterated rounds,
// multi-block bursts with counter increment and a valid/ready beat stream.
module salsa_stream
  import salsa_pkg::*;
#(
  parameter int unsigned ROUNDS = 20,
  parameter int unsigned OUT_W  = 128,
  parameter int unsigned BLK_W  = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               KEY_LOAD,
  input  logic               KEY_MODE,
  input  logic [255:0]       KEY_IN,
  input  logic               NONCE_LOAD,
  input  logic [63:0]        NONCE_IN,
  input  logic [63:0]        CTR_IN,
  input  logic               START,
  input  logic [BLK_W-1:0]   BLOCKS,
  input  logic               ABORT,
  input  logic               KS_READY,
  output logic               KS_VALID,
  output logic [OUT_W-1:0]   KS_DATA,
  output logic               KS_LAST,
  output logic               BUSY,
  output logic [63:0]        CTR_OUT,
  output logic               CTR_WRAP
);

  localparam int unsigned       BEATS     = 512 / OUT_W;
  localparam int unsigned       BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
  localparam logic [4:0]        LAST_RC   = 5'(ROUNDS - 1);
  localparam logic [BLK_W-1:0]  BLK_ZERO  = BLK_W'(0);
  localparam logic [BLK_W-1:0]  BLK_ONE   = BLK_W'(1);
  localparam logic [63:0]       CTR_MAX   = {64{1'b1}};

  state_e             state_q, state_d;
  logic [255:0]       key_q, key_d;
  logic               mode_q, mode_d;
  logic [63:0]        nonce_q, nonce_d;
  logic [63:0]        ctr_q, ctr_d;
  logic [BLK_W-1:0]   remaining_q, remaining_d;
  logic [511:0]       data_q, data_d;
  logic [511:0]       copy_q, copy_d;
  logic [4:0]         rc_q, rc_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic               ks_valid_q, ks_valid_d;
  logic               ks_last_q, ks_last_d;
  logic               busy_q, busy_d;
  logic               ctr_wrap_q, ctr_wrap_d;

  logic [511:0]       init_s;
  logic [511:0]       round_s;
  logic [511:0]       final_s;

  assign init_s = init_matrix(key_q, mode_q, nonce_q, ctr_q);

  salsa_round u_round (
    .matrix_i (data_q),
    .row_sel  (rc_q[0]),
    .matrix_o (round_s)
  );

  // Feed-forward: word-wise sum of the permuted matrix and its initial copy
  always_comb begin
    final_s = '0;
    for (int i = 0; i < 16; i++) final_s[32*i +: 32] = word(data_q, i) + word(copy_q, i);
  end

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    mode_d      = mode_q;
    nonce_d     = nonce_q;
    ctr_d       = ctr_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    copy_d      = copy_q;
    rc_d        = rc_q;
    beat_d      = beat_q;
    ks_valid_d  = ks_valid_q;
    ctr_wrap_d  = 1'b0;

    if (ABORT && (state_q != ST_IDLE)) begin
      // Cancelled block is discarded without touching the counter
      state_d     = ST_IDLE;
      data_d      = '0;
      copy_d      = '0;
      rc_d        = 5'd0;
      beat_d      = '0;
      ks_valid_d  = 1'b0;
      remaining_d = BLK_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (KEY_LOAD) begin
            key_d  = KEY_IN;
            mode_d = KEY_MODE;
          end else begin
            key_d  = key_q;
            mode_d = mode_q;
          end
          if (NONCE_LOAD) begin
            nonce_d = NONCE_IN;
            ctr_d   = CTR_IN;
          end else begin
            nonce_d = nonce_q;
            ctr_d   = ctr_q;
          end
          if (START && (BLOCKS != BLK_ZERO)) begin
            remaining_d = BLOCKS;
            state_d     = ST_INIT;
          end else begin
            state_d     = ST_IDLE;
          end
        end
        ST_INIT: begin
          data_d  = init_s;
          copy_d  = init_s;
          rc_d    = 5'd0;
          state_d = ST_ROUND;
        end
        ST_ROUND: begin
          data_d = round_s;
          rc_d   = rc_q + 5'd1;
          if (rc_q == LAST_RC) begin
            state_d = ST_FINAL;
          end else begin
            state_d = ST_ROUND;
          end
        end
        ST_FINAL: begin
          data_d     = final_s;
          beat_d     = '0;
          ks_valid_d = 1'b1;
          state_d    = ST_OUT;
        end
        ST_OUT: begin
          if (ks_valid_q && KS_READY) begin
            data_d = data_q >> OUT_W;
            if (beat_q == LAST_BEAT) begin
              beat_d      = '0;
              ks_valid_d  = 1'b0;
              ctr_d       = ctr_q + 64'd1;
              ctr_wrap_d  = (ctr_q == CTR_MAX);
              remaining_d = remaining_q - BLK_ONE;
              state_d     = (remaining_q == BLK_ONE) ? ST_IDLE : ST_INIT;
            end else begin
              beat_d      = beat_q + BEAT_ONE;
            end
          end else begin
            data_d = data_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    ks_last_d = ks_valid_d & (beat_d == LAST_BEAT);
    busy_d    = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      key_q       <= '0;
      mode_q      <= 1'b0;
      nonce_q     <= '0;
      ctr_q       <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      copy_q      <= '0;
      rc_q        <= 5'd0;
      beat_q      <= '0;
      ks_valid_q  <= 1'b0;
      ks_last_q   <= 1'b0;
      busy_q      <= 1'b0;
      ctr_wrap_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      mode_q      <= mode_d;
      nonce_q     <= nonce_d;
      ctr_q       <= ctr_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      copy_q      <= copy_d;
      rc_q        <= rc_d;
      beat_q      <= beat_d;
      ks_valid_q  <= ks_valid_d;
      ks_last_q   <= ks_last_d;
      busy_q      <= busy_d;
      ctr_wrap_q  <= ctr_wrap_d;
    end
  end

  assign KS_VALID = ks_valid_q;
  assign KS_DATA  = data_q[OUT_W-1:0];
  assign KS_LAST  = ks_last_q;
  assign BUSY     = busy_q;
  assign CTR_OUT  = ctr_q;
  assign CTR_WRAP = ctr_wrap_q;

endmodule
